// File: rtl/time_pkg.sv
// time_pkg: field limits, widths and load range checking shared by the time counter.
package time_pkg;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int TIME_W   = 8;

    function automatic logic in_range(input logic [TIME_W-1:0] v, input int max);
        return v <= TIME_W'(max);
    endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: wrap-around counter 0..MAX with parallel load and a combinational carry-out.
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         wrap
);
    logic [W-1:0] r_value;

    assign value = r_value;
    assign wrap  = inc && (r_value == W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_value <= '0;
        else if (load)
            r_value <= load_val;
        else if (inc)
            r_value <= wrap ? '0 : r_value + W'(1);
    end
endmodule

// File: rtl/time_counter.sv
// time_counter: 24-hour h:m:s timekeeper with prescaler, validated parallel load and set buttons.
module time_counter
    import time_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              load,
    input  logic [TIME_W-1:0] load_hours,
    input  logic [TIME_W-1:0] load_minutes,
    input  logic [TIME_W-1:0] load_seconds,
    input  logic              inc_hours,
    input  logic              inc_minutes,
    output logic [TIME_W-1:0] hours,
    output logic [TIME_W-1:0] minutes,
    output logic [TIME_W-1:0] seconds,
    output logic              sec_tick,
    output logic              load_err
);
    localparam int PW = $clog2(CYCLES_PER_SEC);

    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    logic          r_load_err;
    logic          w_load_ok;
    logic          w_load_take;
    logic          w_inc_any;
    logic          w_inc_h;
    logic          w_inc_m;
    logic          w_presc_end;
    logic          w_tick;
    logic          w_sec_wrap;
    logic          w_min_wrap;
    logic          w_hour_wrap;

    assign w_load_ok   = in_range(load_hours, HOUR_MAX) && in_range(load_minutes, MIN_MAX)
                         && in_range(load_seconds, SEC_MAX);
    assign w_load_take = load && w_load_ok;
    assign w_inc_h     = inc_hours && !load;
    assign w_inc_m     = inc_minutes && !load;
    assign w_inc_any   = w_inc_h || w_inc_m;
    assign w_presc_end = r_presc == PW'(CYCLES_PER_SEC - 1);
    // Any load (even rejected) or set button steals the tick; it is retried next cycle.
    assign w_tick      = run && w_presc_end && !load && !w_inc_any;

    mod_counter #(.MAX(SEC_MAX), .W(TIME_W)) u_sec (
        .clk(clk), .reset(reset), .inc(w_tick), .load(w_load_take),
        .load_val(load_seconds), .value(seconds), .wrap(w_sec_wrap)
    );

    mod_counter #(.MAX(MIN_MAX), .W(TIME_W)) u_min (
        .clk(clk), .reset(reset), .inc(w_inc_m || w_sec_wrap), .load(w_load_take),
        .load_val(load_minutes), .value(minutes), .wrap(w_min_wrap)
    );

    mod_counter #(.MAX(HOUR_MAX), .W(TIME_W)) u_hour (
        .clk(clk), .reset(reset), .inc(w_inc_h || (w_min_wrap && !w_inc_any)),
        .load(w_load_take), .load_val(load_hours), .value(hours), .wrap(w_hour_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= w_tick;
            r_load_err <= load && !w_load_ok;
            if (w_load_take)
                r_presc <= '0;
            else if (!load && !w_inc_any && run)
                r_presc <= w_presc_end ? '0 : r_presc + PW'(1);
        end
    end

    assign sec_tick = r_sec_tick;
    assign load_err = r_load_err;
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed scoreboard bench for time_counter with CYCLES_PER_SEC=4.
module tb_time_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_hours = '0;
    logic [7:0] load_minutes = '0;
    logic [7:0] load_seconds = '0;
    logic       inc_hours = 1'b0;
    logic       inc_minutes = 1'b0;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       sec_tick;
    logic       load_err;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       tag;
        logic [25:0] v;
    } exp_t;

    exp_t sb[$];

    time_counter #(.CYCLES_PER_SEC(4)) dut (
        .clk(clk), .reset(reset), .run(run), .load(load),
        .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
        .inc_hours(inc_hours), .inc_minutes(inc_minutes),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .sec_tick(sec_tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int h, input int m, input int s,
                        input logic t, input logic e);
        exp_t x;
        x.tag = tag;
        x.v = {8'(h), 8'(m), 8'(s), t, e};
        sb.push_back(x);
    endtask

    task automatic check();
        exp_t x;
        logic [25:0] obs;
        obs = {hours, minutes, seconds, sec_tick, load_err};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty obs=%h exp=none", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.v) else begin
                bad++;
                $error("FAIL %s obs=%0d:%0d:%0d tick=%b err=%b exp=%0d:%0d:%0d tick=%b err=%b",
                       x.tag, obs[25:18], obs[17:10], obs[9:2], obs[1], obs[0],
                       x.v[25:18], x.v[17:10], x.v[9:2], x.v[1], x.v[0]);
            end
        end
    endtask

    task automatic cyc(input string tag, input int h, input int m, input int s,
                       input logic t, input logic e);
        push(tag, h, m, s, t, e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load = 1'b1;
        load_hours = 8'(h);
        load_minutes = 8'(m);
        load_seconds = 8'(s);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push("reset_zero", 0, 0, 0, 0, 0);
        check();
        reset = 1'b0;
        run = 1'b1;
        for (int k = 1; k <= 8; k++)
            cyc("reset_tick", 0, 0, (k >= 8) ? 2 : ((k >= 4) ? 1 : 0), (k == 4) || (k == 8), 1'b0);

        do_load(23, 59, 59);
        cyc("wrap_load", 23, 59, 59, 0, 0);
        load = 1'b0;
        for (int k = 1; k <= 3; k++)
            cyc("wrap_wait", 23, 59, 59, 0, 0);
        cyc("wrap_cascade", 0, 0, 0, 1, 0);
        cyc("wrap_tick_once", 0, 0, 0, 0, 0);

        do_load(5, 6, 7);
        cyc("bad_pre_load", 5, 6, 7, 0, 0);
        load = 1'b0;
        cyc("bad_phase1", 5, 6, 7, 0, 0);
        do_load(24, 10, 10);
        cyc("bad_load_err", 5, 6, 7, 0, 1);
        load = 1'b0;
        cyc("bad_err_once", 5, 6, 7, 0, 0);
        cyc("bad_phase3", 5, 6, 7, 0, 0);
        cyc("bad_on_schedule", 5, 6, 8, 1, 0);

        do_load(23, 59, 30);
        cyc("inc_load", 23, 59, 30, 0, 0);
        load = 1'b0;
        inc_hours = 1'b1;
        inc_minutes = 1'b1;
        cyc("inc_both", 0, 0, 30, 0, 0);
        inc_hours = 1'b0;
        inc_minutes = 1'b0;
        cyc("inc_phase1", 0, 0, 30, 0, 0);
        cyc("inc_phase2", 0, 0, 30, 0, 0);
        cyc("inc_phase3", 0, 0, 30, 0, 0);
        inc_minutes = 1'b1;
        cyc("inc_defers_tick", 0, 1, 30, 0, 0);
        inc_minutes = 1'b0;
        cyc("inc_late_tick", 0, 1, 31, 1, 0);

        do_load(10, 20, 30);
        cyc("pause_load", 10, 20, 30, 0, 0);
        load = 1'b0;
        cyc("pause_phase1", 10, 20, 30, 0, 0);
        cyc("pause_phase2", 10, 20, 30, 0, 0);
        run = 1'b0;
        for (int k = 0; k < 10; k++)
            cyc("pause_frozen", 10, 20, 30, 0, 0);
        run = 1'b1;
        cyc("pause_resume3", 10, 20, 30, 0, 0);
        cyc("pause_resume_tick", 10, 20, 31, 1, 0);
        do_load(1, 2, 3);
        inc_hours = 1'b1;
        cyc("prio_load_wins", 1, 2, 3, 0, 0);
        load = 1'b0;
        inc_hours = 1'b0;

        do_load(12, 34, 56);
        cyc("areset_load", 12, 34, 56, 0, 0);
        load = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        push("areset_immediate", 0, 0, 0, 0, 0);
        check();
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 4; k++)
            cyc("areset_first_tick", 0, 0, (k == 4) ? 1 : 0, k == 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/time_counter.md
# time_counter

Time-keeping core of the digital clock. Counts seconds, minutes and hours in 24-hour binary form from the system clock and drives the 8-bit `hours_in`/`minutes_in`/`seconds_in` inputs of the display decoder, which performs 12-hour/PM conversion downstream. Supports free-running operation, a parallel time load, and button-style hour/minute increments for setting the time.

## Interface
Parameters:
- `CYCLES_PER_SEC`, default 100_000_000: clock cycles per one-second tick; must be ≥ 2. The bench uses 4.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high. Clears all state.
- `run`  in  1  level. 1 lets time advance; 0 freezes the prescaler and the counters.
- `load`  in  1  single-cycle pulse. Loads the three `load_*` values.
- `load_hours`  in  8  binary value, valid range 0–23.
- `load_minutes`  in  8  binary value, valid range 0–59.
- `load_seconds`  in  8  binary value, valid range 0–59.
- `inc_hours`  in  1  single-cycle pulse. Hours +1 mod 24, no carry.
- `inc_minutes`  in  1  single-cycle pulse. Minutes +1 mod 60, no carry into hours.
- `hours`  out  8  0–23, to decoder `hours_in`.
- `minutes`  out  8  0–59, to decoder `minutes_in`.
- `seconds`  out  8  0–59, to decoder `seconds_in`.
- `sec_tick`  out  1  one-cycle pulse, high in the cycle after seconds advance.
- `load_err`  out  1  one-cycle pulse when a `load` is rejected.

## Operation
- Reset: `hours`, `minutes`, `seconds` = 0; prescaler = 0; `sec_tick` = 0; `load_err` = 0.
- Prescaler counts 0..CYCLES_PER_SEC-1 while `run`=1.
- A tick occurs on the edge where prescaler = CYCLES_PER_SEC-1 and `run`=1.
- On a tick:
  - Prescaler goes to 0 and seconds increment.
  - Seconds 59→0 carries to minutes.
  - Minutes 59→0 carries to hours.
  - Hours 23→0 with no further carry.
- Per-cycle priority: `load` > `inc_hours`/`inc_minutes` > tick.
- `load`:
  - If all three values are in range, load them all and clear the prescaler to 0.
  - If any value is out of range, change nothing (prescaler included) and pulse `load_err` on the next cycle.
  - A rejected load still blocks `inc_*` and the tick in that cycle.
  - `load` is honoured regardless of `run`.
- `inc_hours` and `inc_minutes` may be asserted together; both apply. In any cycle with an `inc_*` pulse (and no `load`):
  - the prescaler holds;
  - no tick occurs, so the tick is deferred by one cycle;
  - seconds are unchanged.
- `inc_*` is honoured regardless of `run`.
- `run`=0: prescaler holds its value and does not clear. Resuming continues the partial second.
- Outputs never leave their valid range. Out-of-range values are unreachable except via a rejected load, which has no effect.

## Timing
- All outputs are registered. Updates are visible one cycle after the causing edge.
- Tick cadence with `run` held high: exactly one `seconds` update every CYCLES_PER_SEC cycles. The first tick after reset or load comes CYCLES_PER_SEC cycles after the edge where reset deasserts or the load is taken.
- `sec_tick` is high for exactly one cycle per tick and never on `load`/`inc_*` updates.
- Full cascade 23:59:59→00:00:00 happens in a single cycle with no intermediate values visible.
- Reset asserted mid-count clears immediately (asynchronous). The first tick after deassertion comes CYCLES_PER_SEC cycles later.
- No back-pressure. Pulses wider than one cycle act as repeated pulses, one per cycle.

## Structure
- `time_pkg` holds:
  - `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23;
  - `TIME_W`=8;
  - a range-check function used by load validation.
- Sub-module `mod_counter`, parameterized by MAX and width, with ports:
  - `inc`, `load`, `load_val`;
  - outputs `value` and `wrap`, where `wrap` is combinational and high when `inc` and value = MAX.
- `mod_counter` is instantiated three times and chained through `wrap`. `inc_*` is OR-ed into each stage's `inc` with the carry gated off in that cycle.
- Prescaler and priority logic live in the top level.

## Test plan
All scenarios use CYCLES_PER_SEC=4.
- **Reset and tick:** reset, then `run`=1 for 8 cycles.
  - All outputs 0 at reset.
  - `seconds`=1 after cycle 4 and 2 after cycle 8.
  - `sec_tick` is a single-cycle pulse each time.
- **Full wrap:** load 23:59:59, `run`=1.
  - After 4 cycles: `hours`=0, `minutes`=0, `seconds`=0 together in the same cycle.
  - One `sec_tick`.
- **Bad load:** load 24:10:10 while at 05:06:07.
  - Time stays 05:06:07.
  - `load_err` pulses once.
  - The prescaler phase is unchanged; the next tick is on schedule.
- **Increments:** at 23:59:30, pulse `inc_hours`+`inc_minutes` together → 00:00:30, seconds unchanged. Then pulse `inc_minutes` in the tick cycle → tick deferred one cycle, `seconds` 31 one cycle late.
- **Pause and priority:** `run`=0 for 10 cycles mid-second → no change; resume → tick after the remaining cycles only. Then `load` and `inc_hours` in the same cycle → loaded value wins.
- **Async reset:** assert `reset` between clock edges at 12:34:56 → outputs read 0 before the next edge.
